// File: rtl/piano_pkg.sv
// Shared constants for the piano input conditioner: key indices, octave
// limits and the amplifier-enable state encoding.
package piano_pkg;

  localparam int NUM_KEYS = 12;

  localparam int KEY_C  = 0;
  localparam int KEY_CS = 1;
  localparam int KEY_D  = 2;
  localparam int KEY_DS = 3;
  localparam int KEY_E  = 4;
  localparam int KEY_F  = 5;
  localparam int KEY_FS = 6;
  localparam int KEY_G  = 7;
  localparam int KEY_GS = 8;
  localparam int KEY_A  = 9;
  localparam int KEY_AS = 10;
  localparam int KEY_B  = 11;

  localparam logic [2:0] OCTAVE_MIN = 3'd0;
  localparam logic [2:0] OCTAVE_MAX = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    RELEASE = 2'd2
  } play_state_e;

endpackage

// File: rtl/debounce_bit.sv
// One input channel: 2-flop synchroniser followed by a stable-level
// debouncer that accepts a new level after DEBOUNCE_CYCLES steady cycles.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_TC) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/piano_input_conditioner.sv
// Debounces keys and buttons, tracks the octave, and holds the amplifier
// enable through a release tail after the last key goes up.
//
// state   | meaning
// IDLE    | no key held, amplifier off
// PLAYING | at least one key held, amplifier on
// RELEASE | keys released, amplifier held on until the tail timer expires
module piano_input_conditioner #(
  parameter int         NUM_KEYS        = piano_pkg::NUM_KEYS,
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter int         RELEASE_CYCLES  = 5000000,
  parameter logic [2:0] OCTAVE_RESET    = 3'd4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] raw_keys,
  input  logic                btn_oct_up,
  input  logic                btn_oct_down,
  input  logic                btn_vol_up,
  input  logic                btn_vol_down,
  output logic [NUM_KEYS-1:0] piano_keys,
  output logic [2:0]          octave_num,
  output logic                play_en,
  output logic                vol_up,
  output logic                vol_down,
  output logic                key_active
);

  import piano_pkg::*;

  localparam int NCH = NUM_KEYS + 4;
  localparam int TW  = $clog2(RELEASE_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(RELEASE_CYCLES - 1);

  logic [NCH-1:0] raw_all, stable_all;
  logic [3:0]     btn_stable, btn_q, btn_pulse;
  logic [2:0]     octave_q, octave_d;
  play_state_e    state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           play_en_q;

  // Channel order above the keys: oct_up, oct_down, vol_up, vol_down.
  assign raw_all = {btn_vol_down, btn_vol_up, btn_oct_down, btn_oct_up, raw_keys};

  for (genvar i = 0; i < NCH; i++) begin : g_db
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .resetn (resetn),
      .din    (raw_all[i]),
      .dout   (stable_all[i])
    );
  end

  assign piano_keys = stable_all[NUM_KEYS-1:0];
  assign key_active = |piano_keys;
  assign btn_stable = stable_all[NUM_KEYS +: 4];
  assign btn_pulse  = btn_stable & ~btn_q;
  assign vol_up     = btn_pulse[2];
  assign vol_down   = btn_pulse[3];

  // Octave moves are dropped while a note sounds so pitch never jumps mid-note.
  always_comb begin
    octave_d = octave_q;
    if (!key_active) begin
      if (btn_pulse[0] && !btn_pulse[1] && octave_q != OCTAVE_MAX) begin
        octave_d = octave_q + 3'd1;
      end else if (btn_pulse[1] && !btn_pulse[0] && octave_q != OCTAVE_MIN) begin
        octave_d = octave_q - 3'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (key_active) state_d = PLAYING;
      end
      PLAYING: begin
        if (!key_active) begin
          state_d = RELEASE;
          timer_d = TIMER_LOAD;
        end
      end
      RELEASE: begin
        if (key_active) begin
          state_d = PLAYING;
        end else if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_q     <= '0;
      octave_q  <= OCTAVE_RESET;
      state_q   <= IDLE;
      timer_q   <= '0;
      play_en_q <= 1'b0;
    end else begin
      btn_q     <= btn_stable;
      octave_q  <= octave_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      play_en_q <= (state_d != IDLE);
    end
  end

  assign octave_num = octave_q;
  assign play_en    = play_en_q;

endmodule

// File: tb/tb_piano_input_conditioner.sv
// Directed bench for piano_input_conditioner with short debounce and
// release times; expected values are worked out by hand from the timing rules.
module tb_piano_input_conditioner;

  localparam int NK  = 12;
  localparam int DB  = 4;
  localparam int REL = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic [NK-1:0] raw_keys;
  logic [3:0]    btn;
  logic [NK-1:0] piano_keys;
  logic [2:0]    octave_num;
  logic          play_en, vol_up, vol_down, key_active;

  int n_checks = 0;
  int n_fail   = 0;

  piano_input_conditioner #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DB),
    .RELEASE_CYCLES  (REL),
    .OCTAVE_RESET    (3'd4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .raw_keys     (raw_keys),
    .btn_oct_up   (btn[0]),
    .btn_oct_down (btn[1]),
    .btn_vol_up   (btn[2]),
    .btn_vol_down (btn[3]),
    .piano_keys   (piano_keys),
    .octave_num   (octave_num),
    .play_en      (play_en),
    .vol_up       (vol_up),
    .vol_down     (vol_down),
    .key_active   (key_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold long enough to be accepted, then release long enough to settle low.
  task automatic press(input int idx);
    btn[idx] = 1'b1;
    step(DB + 4);
    btn[idx] = 1'b0;
    step(DB + 4);
  endtask

  int cnt;
  int drops;
  logic [2:0] oct_seq [5];

  initial begin
    resetn   = 1'b0;
    raw_keys = '0;
    btn      = '0;
    oct_seq  = '{3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
    step(2);
    chk("rst_keys", 32'(piano_keys), 32'h0);
    chk("rst_oct", 32'(octave_num), 32'd4);
    chk("rst_play", 32'(play_en), 32'd0);
    resetn = 1'b1;
    step(3);
    chk("idle_outs", {piano_keys, octave_num, play_en, vol_up, vol_down, key_active}, {12'h0, 3'd4, 4'b0000});

    // Short glitch on key A is rejected.
    raw_keys[9] = 1'b1;
    step(3);
    raw_keys[9] = 1'b0;
    step(8);
    chk("glitch_keys", 32'(piano_keys), 32'h0);
    chk("glitch_play", 32'(play_en), 32'd0);

    // Held key A accepted exactly 6 edges after the raw edge.
    raw_keys[9] = 1'b1;
    step(5);
    chk("keyA_edge5", 32'(piano_keys), 32'h0);
    step(1);
    chk("keyA_edge6", 32'(piano_keys), 32'h200);
    chk("keyA_active", 32'(key_active), 32'd1);
    chk("keyA_play_lag", 32'(play_en), 32'd0);
    step(1);
    chk("keyA_play", 32'(play_en), 32'd1);

    // Release: play_en held REL+1 edges after key_active falls.
    raw_keys[9] = 1'b0;
    step(6);
    chk("rel_active", 32'(key_active), 32'd0);
    step(8);
    chk("rel_tail_end", 32'(play_en), 32'd1);
    step(1);
    chk("rel_off", 32'(play_en), 32'd0);

    // Re-press during the tail: play_en never drops.
    raw_keys[9] = 1'b1;
    step(8);
    raw_keys[9] = 1'b0;
    step(6);
    raw_keys[9] = 1'b1;
    drops = 0;
    for (int i = 0; i < 14; i++) begin
      step(1);
      if (play_en !== 1'b1) drops++;
    end
    chk("repress_drops", 32'(drops), 32'd0);
    raw_keys[9] = 1'b0;
    step(20);
    chk("repress_idle", 32'(play_en), 32'd0);

    // Octave up saturates at 7, down saturates at 0.
    for (int i = 0; i < 5; i++) begin
      press(0);
      chk($sformatf("oct_up%0d", i), 32'(octave_num), 32'(oct_seq[i]));
    end
    for (int i = 0; i < 8; i++) press(1);
    chk("oct_down_floor", 32'(octave_num), 32'd0);

    // Octave request discarded while a key is held.
    raw_keys[0] = 1'b1;
    step(8);
    press(0);
    chk("oct_keyheld", 32'(octave_num), 32'd0);
    raw_keys[0] = 1'b0;
    step(20);
    press(0);
    chk("oct_up_free", 32'(octave_num), 32'd1);

    // Holding vol_up gives exactly one single-cycle pulse.
    cnt = 0;
    drops = 0;
    btn[2] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (vol_up === 1'b1) cnt++;
      if (vol_down === 1'b1) drops++;
    end
    btn[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (vol_up === 1'b1) cnt++;
    end
    chk("vol_up_pulses", 32'(cnt), 32'd1);
    chk("vol_down_idle", 32'(drops), 32'd0);

    // Two-cycle glitches on vol_down are rejected.
    cnt = 0;
    for (int g = 0; g < 5; g++) begin
      btn[3] = 1'b1;
      for (int i = 0; i < 2; i++) begin
        step(1);
        if (vol_down === 1'b1) cnt++;
      end
      btn[3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        step(1);
        if (vol_down === 1'b1) cnt++;
      end
    end
    step(6);
    if (vol_down === 1'b1) cnt++;
    chk("vol_down_glitch", 32'(cnt), 32'd0);

    // Chord C,E,G then release E only.
    raw_keys = 12'h091;
    step(6);
    chk("chord_keys", 32'(piano_keys), 32'h091);
    chk("chord_active", 32'(key_active), 32'd1);
    step(1);
    chk("chord_play", 32'(play_en), 32'd1);
    raw_keys = 12'h081;
    step(6);
    chk("chord_relE", 32'(piano_keys), 32'h081);
    chk("chord_relE_play", 32'(play_en), 32'd1);

    // Reset in the middle of the release tail.
    raw_keys = '0;
    step(6);
    step(4);
    chk("tail_play", 32'(play_en), 32'd1);
    chk("tail_oct", 32'(octave_num), 32'd1);
    resetn = 1'b0;
    #1;
    chk("midrel_rst_play", 32'(play_en), 32'd0);
    chk("midrel_rst_oct", 32'(octave_num), 32'd4);
    step(2);
    resetn = 1'b1;
    step(12);
    chk("post_rst", {piano_keys, octave_num, play_en, vol_up, vol_down, key_active}, {12'h0, 3'd4, 4'b0000});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
